uart_msg_port: RTL and testbench

- Parametrised message framing engine between the UART byte layer (uart_rx/uart_tx) and the controller.
- Replaces the separate assembler, disassembler and two FIFOs with one block.
- Adds an inter-byte timeout resync, configurable byte order, and saturating error counters.
- RX path: bytes → WORDS_PER_MSG-byte messages → RX FIFO → controller. TX path: controller → TX FIFO → bytes → uart_tx.

---
 rtl/uart_msg_pkg.sv | 21 ++
 rtl/msg_fifo.sv | 50 +++++
 rtl/uart_msg_port.sv | 170 +++++++++++++++++
 tb/tb_uart_msg_port.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the UART message port: message width helper,
// message type, TX sequencer states and the error counter width.
package uart_msg_pkg;

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int DEFAULT_MSG_WIDTH = 32;

   typedef logic [DEFAULT_MSG_WIDTH-1:0] msg_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SEND,
      TX_GAP
   } tx_state_t;

   function automatic int msg_width(input int word_size, input int words_per_msg);
      return word_size * words_per_msg;
   endfunction

endpackage

// File: rtl/msg_fifo.sv
// Show-ahead message FIFO. A push while full is accepted only when a pop
// happens in the same cycle, so a full FIFO can stream without dropping.
module msg_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   // Head is forced to zero when empty so stale storage never shows after reset.
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (!do_push && do_pop) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_msg_port.sv
// Message framing engine between the UART byte layer and the controller:
// assembles RX words into messages and serialises TX messages into words.
module uart_msg_port
   import uart_msg_pkg::*;
#(
   parameter int WORD_SIZE     = 8,
   parameter int WORDS_PER_MSG = 4,
   parameter int RX_FIFO_DEPTH = 8,
   parameter int TX_FIFO_DEPTH = 8,
   parameter int TIMEOUT_CLKS  = 12000,
   parameter int MSB_FIRST     = 1,
   localparam int MSG_WIDTH    = msg_width(WORD_SIZE, WORDS_PER_MSG)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] rx_data,
   input  logic                 rx_valid,
   input  logic                 tx_ready,
   output logic                 tx_start,
   output logic [WORD_SIZE-1:0] tx_data,
   output logic [MSG_WIDTH-1:0] in_msg,
   output logic                 in_avail,
   input  logic                 in_req,
   output logic                 in_full,
   input  logic [MSG_WIDTH-1:0] out_msg,
   input  logic                 out_req,
   output logic                 out_full,
   output logic [CNT_W-1:0]     rx_overrun_cnt,
   output logic [CNT_W-1:0]     rx_timeout_cnt
);

   localparam int WC_W   = $clog2(WORDS_PER_MSG);
   localparam int IDLE_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

   logic [WC_W-1:0]      word_cnt;
   logic [IDLE_W-1:0]    idle_cnt;
   logic [MSG_WIDTH-1:0] rx_msg;
   logic [MSG_WIDTH-1:0] rx_next_msg;
   logic                 rx_last;
   logic                 rx_push;
   logic                 rx_empty;
   logic                 rx_overrun;
   logic                 timeout_hit;

   assign rx_last     = (word_cnt == WC_W'(WORDS_PER_MSG - 1));
   assign rx_push     = rx_valid && rx_last;
   assign rx_overrun  = rx_push && in_full && !in_req;
   assign in_avail    = !rx_empty;
   assign timeout_hit = (TIMEOUT_CLKS != 0) && (word_cnt != '0) && !rx_valid &&
                        (idle_cnt == IDLE_W'(TIMEOUT_CLKS - 1));

   // The completing word is merged combinationally so the full message can be
   // pushed on the same edge that receives its last word.
   always_comb begin
      rx_next_msg = rx_msg;
      if (MSB_FIRST != 0)
         rx_next_msg[(WORDS_PER_MSG - 1 - int'(word_cnt)) * WORD_SIZE +: WORD_SIZE] = rx_data;
      else
         rx_next_msg[int'(word_cnt) * WORD_SIZE +: WORD_SIZE] = rx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_cnt       <= '0;
         idle_cnt       <= '0;
         rx_msg         <= '0;
         rx_timeout_cnt <= '0;
         rx_overrun_cnt <= '0;
      end else begin
         if (rx_valid) begin
            rx_msg   <= rx_next_msg;
            word_cnt <= rx_last ? '0 : word_cnt + WC_W'(1);
            idle_cnt <= '0;
         end else if (word_cnt == '0) begin
            idle_cnt <= '0;
         end else if (timeout_hit) begin
            word_cnt <= '0;
            idle_cnt <= '0;
            if (rx_timeout_cnt != CNT_MAX) rx_timeout_cnt <= rx_timeout_cnt + CNT_W'(1);
         end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
         end
         if (rx_overrun && rx_overrun_cnt != CNT_MAX)
            rx_overrun_cnt <= rx_overrun_cnt + CNT_W'(1);
      end
   end

   msg_fifo #(
      .WIDTH (MSG_WIDTH),
      .DEPTH (RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_push),
      .push_data (rx_next_msg),
      .pop       (in_req),
      .head      (in_msg),
      .full      (in_full),
      .empty     (rx_empty)
   );

   tx_state_t            state;
   tx_state_t            nxt;
   logic [WC_W-1:0]      tx_cnt;
   logic [MSG_WIDTH-1:0] tx_shift;
   logic [MSG_WIDTH-1:0] tx_head;
   logic [WORD_SIZE-1:0] tx_cur;
   logic [WORD_SIZE-1:0] tx_last_data;
   logic                 tx_empty;
   logic                 tx_pop;
   logic                 tx_last_word;

   assign tx_cur       = (MSB_FIRST != 0) ? tx_shift[MSG_WIDTH-1 -: WORD_SIZE]
                                          : tx_shift[WORD_SIZE-1:0];
   assign tx_last_word = (tx_cnt == WC_W'(WORDS_PER_MSG - 1));

   msg_fifo #(
      .WIDTH (MSG_WIDTH),
      .DEPTH (TX_FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (out_req),
      .push_data (out_msg),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (out_full),
      .empty     (tx_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= TX_IDLE;
      else       state <= nxt;
   end

   // GAP lasts one cycle because uart_tx only drops ready after seeing start.
   always_comb begin
      nxt = state;
      case (state)
         TX_IDLE: if (!tx_empty) nxt = TX_SEND;
         TX_SEND: if (tx_start) nxt = TX_GAP;
         TX_GAP:  nxt = tx_last_word ? TX_IDLE : TX_SEND;
         default: nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_pop   = (state == TX_IDLE) && !tx_empty;
      tx_start = (state == TX_SEND) && tx_ready;
      tx_data  = tx_start ? tx_cur : tx_last_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_shift     <= '0;
         tx_cnt       <= '0;
         tx_last_data <= '0;
      end else begin
         if (tx_pop) begin
            tx_shift <= tx_head;
            tx_cnt   <= '0;
         end else if (tx_start) begin
            tx_shift <= (MSB_FIRST != 0) ? (tx_shift << WORD_SIZE) : (tx_shift >> WORD_SIZE);
         end
         if (state == TX_GAP && !tx_last_word) tx_cnt <= tx_cnt + WC_W'(1);
         if (tx_start) tx_last_data <= tx_cur;
      end
   end

endmodule

// File: tb/tb_uart_msg_port.sv
// Directed scoreboard bench for uart_msg_port: RX assembly, timeout resync,
// overrun, TX serialisation with a uart_tx ready model, and mid-message reset.
module tb_uart_msg_port;
   import uart_msg_pkg::*;

   localparam int T = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tx_ready = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [31:0] in_msg;
   logic        in_avail;
   logic        in_req;
   logic        in_full;
   logic [31:0] out_msg;
   logic        out_req;
   logic        out_full;
   logic [7:0]  rx_overrun_cnt;
   logic [7:0]  rx_timeout_cnt;

   logic        lsb_tx_start;
   logic [7:0]  lsb_tx_data;
   logic [31:0] lsb_in_msg;
   logic        lsb_in_avail;
   logic        lsb_in_full;
   logic        lsb_out_full;
   logic [7:0]  lsb_overrun_cnt;
   logic [7:0]  lsb_timeout_cnt;

   int          checks = 0;
   int          passes = 0;
   msg_t        rx_q[$];
   logic [7:0]  tx_q[$];
   bit          ready_en = 1'b1;
   bit          start_seen = 1'b0;
   int          busy = 0;

   uart_msg_port #(
      .WORD_SIZE (8), .WORDS_PER_MSG (4), .RX_FIFO_DEPTH (8), .TX_FIFO_DEPTH (8),
      .TIMEOUT_CLKS (T), .MSB_FIRST (1)
   ) dut (
      .clk (clk), .reset (reset), .rx_data (rx_data), .rx_valid (rx_valid),
      .tx_ready (tx_ready), .tx_start (tx_start), .tx_data (tx_data),
      .in_msg (in_msg), .in_avail (in_avail), .in_req (in_req), .in_full (in_full),
      .out_msg (out_msg), .out_req (out_req), .out_full (out_full),
      .rx_overrun_cnt (rx_overrun_cnt), .rx_timeout_cnt (rx_timeout_cnt)
   );

   uart_msg_port #(
      .WORD_SIZE (8), .WORDS_PER_MSG (4), .RX_FIFO_DEPTH (8), .TX_FIFO_DEPTH (8),
      .TIMEOUT_CLKS (T), .MSB_FIRST (0)
   ) dut_lsb (
      .clk (clk), .reset (reset), .rx_data (rx_data), .rx_valid (rx_valid),
      .tx_ready (tx_ready), .tx_start (lsb_tx_start), .tx_data (lsb_tx_data),
      .in_msg (lsb_in_msg), .in_avail (lsb_in_avail), .in_req (in_req), .in_full (lsb_in_full),
      .out_msg (out_msg), .out_req (out_req), .out_full (lsb_out_full),
      .rx_overrun_cnt (lsb_overrun_cnt), .rx_timeout_cnt (lsb_timeout_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // uart_tx model: ready drops the cycle after a start and stays low for 10 cycles.
   always @(posedge clk) begin
      #1;
      if (start_seen) busy = 10;
      else if (busy > 0) busy--;
      tx_ready = ready_en && (busy == 0);
   end

   always @(negedge clk) begin
      start_seen = (tx_start === 1'b1);
      if (tx_start === 1'b1) begin
         if (tx_q.size() == 0) checkOutput("tx_unexpected_start", 64'd1, 64'd0);
         else checkOutput("tx_byte", 64'(tx_data), 64'(tx_q.pop_front()));
      end
   end

   task automatic applyStimulus(input logic [7:0] b, input bit pop);
      rx_valid = 1'b1;
      rx_data  = b;
      in_req   = pop;
      @(negedge clk);
      rx_valid = 1'b0;
      in_req   = 1'b0;
   endtask

   task automatic sendMsg(input msg_t m, input bit pop_last);
      for (int k = 3; k >= 0; k--) applyStimulus(m[k*8 +: 8], pop_last && (k == 0));
   endtask

   task automatic popRx(input string tag);
      checkOutput({tag, "_avail"}, 64'(in_avail), 64'd1);
      if (rx_q.size() == 0) checkOutput({tag, "_queue"}, 64'd1, 64'd0);
      else checkOutput(tag, 64'(in_msg), 64'(rx_q.pop_front()));
      in_req = 1'b1;
      @(negedge clk);
      in_req = 1'b0;
   endtask

   task automatic pushTx(input msg_t m, input bit expect_sent);
      out_req = 1'b1;
      out_msg = m;
      if (expect_sent)
         for (int k = 3; k >= 0; k--) tx_q.push_back(m[k*8 +: 8]);
      @(negedge clk);
      out_req = 1'b0;
   endtask

   task automatic waitTxDrain(input string tag, input int budget);
      int n = 0;
      while (tx_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 64'(tx_q.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int starts;
      reset = 1'b1; rx_data = '0; rx_valid = 1'b0; in_req = 1'b0;
      out_msg = '0; out_req = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_in_avail", 64'(in_avail), 64'd0);
      checkOutput("rst_in_msg", 64'(in_msg), 64'd0);
      checkOutput("rst_tx_start", 64'(tx_start), 64'd0);
      checkOutput("rst_full", 64'({in_full, out_full}), 64'd0);
      checkOutput("rst_counters", 64'({rx_overrun_cnt, rx_timeout_cnt}), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Basic assembly in both byte orders
      sendMsg(32'h12345678, 1'b0);
      rx_q.push_back(32'h12345678);
      checkOutput("lsb_first_msg", 64'(lsb_in_msg), 64'h78563412);
      popRx("rx_msb_first");
      checkOutput("rx_empty_after_pop", 64'(in_avail), 64'd0);

      // Timeout discards a partial message
      applyStimulus(8'h11, 1'b0); applyStimulus(8'h22, 1'b0); applyStimulus(8'h33, 1'b0);
      repeat (T) @(negedge clk);
      checkOutput("timeout_cnt_1", 64'(rx_timeout_cnt), 64'd1);
      checkOutput("timeout_no_msg", 64'(in_avail), 64'd0);
      sendMsg(32'hAABBCCDD, 1'b0);
      rx_q.push_back(32'hAABBCCDD);
      popRx("rx_after_timeout");
      checkOutput("single_msg_after_timeout", 64'(in_avail), 64'd0);

      // Word landing exactly on the expiry cycle wins
      applyStimulus(8'h44, 1'b0); applyStimulus(8'h55, 1'b0); applyStimulus(8'h66, 1'b0);
      repeat (T - 1) @(negedge clk);
      applyStimulus(8'h77, 1'b0);
      rx_q.push_back(32'h44556677);
      checkOutput("expiry_rx_wins_cnt", 64'(rx_timeout_cnt), 64'd1);
      popRx("rx_expiry_cycle");

      // Overrun, then push+pop while full
      for (int i = 0; i < 9; i++) begin
         sendMsg(32'h10000000 + 32'(i), 1'b0);
         if (i < 8) rx_q.push_back(32'h10000000 + 32'(i));
      end
      checkOutput("in_full", 64'(in_full), 64'd1);
      checkOutput("overrun_cnt_1", 64'(rx_overrun_cnt), 64'd1);
      checkOutput("pop_when_full_head", 64'(in_msg), 64'(rx_q.pop_front()));
      sendMsg(32'hCAFEF00D, 1'b1);
      rx_q.push_back(32'hCAFEF00D);
      checkOutput("overrun_unchanged", 64'(rx_overrun_cnt), 64'd1);
      checkOutput("still_full", 64'(in_full), 64'd1);
      for (int i = 0; i < 8; i++) popRx("rx_drain");
      checkOutput("rx_drained", 64'(in_avail), 64'd0);

      // TX latency and byte order
      pushTx(32'hDEADBEEF, 1'b1);
      checkOutput("tx_lat_early", 64'(tx_start), 64'd0);
      @(negedge clk);
      checkOutput("tx_lat_first", 64'(tx_start), 64'd1);
      waitTxDrain("tx_drain_single", 200);
      @(negedge clk);
      checkOutput("tx_data_hold_start", 64'(tx_start), 64'd0);
      checkOutput("tx_data_hold", 64'(tx_data), 64'hEF);

      // Fill the TX FIFO with the uart held busy
      ready_en = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         pushTx(32'hA0B0C0D0 + 32'(i * 32'h01010101), 1'b1);
         if (i == 7) checkOutput("out_full_after_8", 64'(out_full), 64'd0);
         if (i == 8) checkOutput("out_full_after_9", 64'(out_full), 64'd1);
      end
      ready_en = 1'b1;
      waitTxDrain("tx_drain_burst", 1000);
      checkOutput("out_full_cleared", 64'(out_full), 64'd0);
      repeat (15) @(negedge clk);

      // Reset mid-RX and mid-TX
      ready_en = 1'b0;
      repeat (3) @(negedge clk);
      sendMsg(32'h0BADF00D, 1'b0);
      applyStimulus(8'hE1, 1'b0); applyStimulus(8'hE2, 1'b0);
      pushTx(32'h55667788, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_tx_start", 64'(tx_start), 64'd0);
      checkOutput("mid_rst_tx_data", 64'(tx_data), 64'd0);
      checkOutput("mid_rst_in_avail", 64'(in_avail), 64'd0);
      checkOutput("mid_rst_in_msg", 64'(in_msg), 64'd0);
      checkOutput("mid_rst_counters", 64'({rx_overrun_cnt, rx_timeout_cnt}), 64'd0);
      ready_en = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      starts = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (tx_start === 1'b1) starts++;
      end
      checkOutput("no_tx_after_reset", 64'(starts), 64'd0);
      sendMsg(32'h01020304, 1'b0);
      rx_q.push_back(32'h01020304);
      popRx("rx_clean_after_reset");
      checkOutput("rx_queue_consumed", 64'(rx_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
